id_ex_stage: RTL and testbench

- ID/EX pipeline register of the in-order 5-stage core. Sits between decode and the EX-stage ALU.
- Captures decoded instructions and selects forwarded operands, then drives the ALU inputs Ain, Bin, IDEXop, IDEXfunct3 and IDEXfunct7.
- Detects load-use hazards, stalls decode and inserts a bubble.
- Honours back-pressure stalls from downstream and branch flushes.

---
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions, detects load-use hazards,
// and forwards EX/MEM and MEM/WB results onto the EX-stage ALU operands.
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [6:0]      id_op,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            exmem_regwrite,
  input  logic            exmem_is_load,
  input  logic [REGW-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            stall_in,
  input  logic            flush,
  output logic            id_stall,
  output logic            idex_valid,
  output logic [6:0]      IDEXop,
  output logic [2:0]      IDEXfunct3,
  output logic [6:0]      IDEXfunct7,
  output logic [REGW-1:0] idex_rd,
  output logic            idex_regwrite,
  output logic [XLEN-1:0] Ain,
  output logic [XLEN-1:0] Bin,
  output logic [XLEN-1:0] idex_store_data
);

  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] ALUopI = 7'b0010011;
  localparam logic [6:0] ALUopR = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] imm;
  } idex_t;

  idex_t idex_q, idex_d, capture;

  logic            idUsesRs1, idUsesRs2, loadUse;
  logic [XLEN-1:0] fwdRs1, fwdRs2;

  always_comb begin
    idUsesRs1 = (id_op == LW) || (id_op == SW) || (id_op == ALUopI) || (id_op == ALUopR);
    idUsesRs2 = (id_op == SW) || (id_op == ALUopR);
    loadUse   = idex_q.valid && (idex_q.op == LW) && (idex_q.rd != '0) && id_valid &&
                ((idUsesRs1 && (id_rs1 == idex_q.rd)) || (idUsesRs2 && (id_rs2 == idex_q.rd)));
    id_stall  = loadUse && !reset && !flush;
  end

  // The register file is written at the end of the cycle, so the write-back value
  // must be captured directly or the instruction would latch stale data.
  always_comb begin
    capture         = '0;
    capture.valid   = id_valid;
    capture.op      = id_op;
    capture.funct3  = id_funct3;
    capture.funct7  = id_funct7;
    capture.rs1     = id_rs1;
    capture.rs2     = id_rs2;
    capture.rd      = id_rd;
    capture.imm     = id_imm;
    capture.rs1Data = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs1) ? memwb_result : id_rs1_data;
    capture.rs2Data = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs2) ? memwb_result : id_rs2_data;
  end

  always_comb begin
    idex_d = idex_q;
    if (flush)         idex_d = '0;
    else if (stall_in) idex_d = idex_q;
    else if (id_stall) idex_d = '0;
    else               idex_d = capture;
  end

  always_ff @(posedge clock) begin
    if (reset) idex_q <= '0;
    else       idex_q <= idex_d;
  end

  // A load in EX/MEM has no data yet; the hazard bubble lets MEM/WB supply it instead.
  always_comb begin
    fwdRs1 = idex_q.rs1Data;
    if (exmem_regwrite && !exmem_is_load && exmem_rd != '0 && exmem_rd == idex_q.rs1)
      fwdRs1 = exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_q.rs1)
      fwdRs1 = memwb_result;

    fwdRs2 = idex_q.rs2Data;
    if (exmem_regwrite && !exmem_is_load && exmem_rd != '0 && exmem_rd == idex_q.rs2)
      fwdRs2 = exmem_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == idex_q.rs2)
      fwdRs2 = memwb_result;
  end

  always_comb begin
    idex_valid      = idex_q.valid;
    IDEXop          = idex_q.op;
    IDEXfunct3      = idex_q.funct3;
    IDEXfunct7      = idex_q.funct7;
    idex_rd         = idex_q.rd;
    idex_regwrite   = idex_q.valid && (idex_q.rd != '0) &&
                      ((idex_q.op == LW) || (idex_q.op == ALUopI) || (idex_q.op == ALUopR));
    Ain             = '0;
    Bin             = '0;
    idex_store_data = '0;
    if (idex_q.valid) begin
      Ain             = fwdRs1;
      idex_store_data = fwdRs2;
      if (idex_q.op == ALUopR)
        Bin = fwdRs2;
      else if ((idex_q.op == LW) || (idex_q.op == SW) || (idex_q.op == ALUopI))
        Bin = idex_q.imm;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: reset, forwarding, load-use,
// flush/stall priority, x0 handling and store-data forwarding.
module tb_id_ex_stage;

  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] ALUopI = 7'b0010011;
  localparam logic [6:0] ALUopR = 7'b0110011;
  localparam logic [6:0] OPSYS  = 7'b1110011;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [6:0]  id_op, id_funct7;
  logic [2:0]  id_funct3;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        exmem_regwrite, exmem_is_load;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic        stall_in, flush;
  logic        id_stall, idex_valid, idex_regwrite;
  logic [6:0]  IDEXop, IDEXfunct7;
  logic [2:0]  IDEXfunct3;
  logic [4:0]  idex_rd;
  logic [31:0] Ain, Bin, idex_store_data;

  int checks = 0;
  int errors = 0;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_op(id_op), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load),
    .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_in(stall_in), .flush(flush),
    .id_stall(id_stall), .idex_valid(idex_valid),
    .IDEXop(IDEXop), .IDEXfunct3(IDEXfunct3), .IDEXfunct7(IDEXfunct7),
    .idex_rd(idex_rd), .idex_regwrite(idex_regwrite),
    .Ain(Ain), .Bin(Bin), .idex_store_data(idex_store_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm);
    id_valid = v; id_op = op; id_funct3 = f3; id_funct7 = f7;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
  endtask

  task automatic setForward(input logic exRw, input logic exLd, input logic [4:0] exRd,
                            input logic [31:0] exRes, input logic wbRw, input logic [4:0] wbRd,
                            input logic [31:0] wbRes);
    exmem_regwrite = exRw; exmem_is_load = exLd; exmem_rd = exRd; exmem_result = exRes;
    memwb_regwrite = wbRw; memwb_rd = wbRd; memwb_result = wbRes;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, ALUopR, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0);
    tick();
    checks++; if (idex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h expected 0", idex_valid); end
    checks++; if (IDEXop !== 7'd0) begin errors++; $display("[TB] FAIL reset_op got %0h expected 0", IDEXop); end
    checks++; if (Ain !== 32'h0 || Bin !== 32'h0) begin errors++; $display("[TB] FAIL reset_operands got Ain=%0h Bin=%0h expected 0", Ain, Bin); end
    checks++; if (id_stall !== 1'b0 || idex_regwrite !== 1'b0 || idex_store_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_misc got stall=%0b rw=%0b sd=%0h expected 0", id_stall, idex_regwrite, idex_store_data); end
    reset = 1'b0;
  endtask

  task automatic test_double_forward();
    applyStimulus(1'b1, ALUopR, 3'd0, 7'd0, 5'd5, 5'd5, 5'd7, 32'h1, 32'h2, 32'h0);
    tick();
    setForward(1'b1, 1'b0, 5'd5, 32'h10, 1'b1, 5'd5, 32'h20);
    #1;
    checks++; if (Ain !== 32'h10 || Bin !== 32'h10) begin errors++; $display("[TB] FAIL dbl_fwd got Ain=%0h Bin=%0h expected 10/10", Ain, Bin); end
    checks++; if (idex_regwrite !== 1'b1 || idex_rd !== 5'd7 || IDEXop !== ALUopR) begin errors++; $display("[TB] FAIL dbl_fwd_ctrl got rw=%0b rd=%0d op=%0h expected 1/7/%0h", idex_regwrite, idex_rd, IDEXop, ALUopR); end
    exmem_is_load = 1'b1;
    #1;
    checks++; if (Ain !== 32'h20) begin errors++; $display("[TB] FAIL load_no_exfwd got %0h expected 20", Ain); end
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (Ain !== 32'h1 || Bin !== 32'h2) begin errors++; $display("[TB] FAIL no_fwd got Ain=%0h Bin=%0h expected 1/2", Ain, Bin); end
  endtask

  task automatic test_load_use();
    applyStimulus(1'b1, LW, 3'd2, 7'd0, 5'd2, 5'd0, 5'd3, 32'h100, 32'h0, 32'h4);
    tick();
    checks++; if (IDEXop !== LW || Ain !== 32'h100 || Bin !== 32'h4) begin errors++; $display("[TB] FAIL lw_capture got op=%0h Ain=%0h Bin=%0h expected 03/100/4", IDEXop, Ain, Bin); end
    applyStimulus(1'b1, ALUopI, 3'd0, 7'd0, 5'd1, 5'd3, 5'd4, 32'h7, 32'h0, 32'h1);
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL rs2_unused_stall got %0b expected 0", id_stall); end
    applyStimulus(1'b1, ALUopR, 3'd0, 7'd0, 5'd3, 5'd1, 5'd4, 32'hDEAD, 32'h7, 32'h0);
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("[TB] FAIL load_use_stall got %0b expected 1", id_stall); end
    flush = 1'b1;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("[TB] FAIL flush_masks_stall got %0b expected 0", id_stall); end
    flush = 1'b0;
    tick();
    checks++; if (idex_valid !== 1'b0 || IDEXop !== 7'd0 || Ain !== 32'h0 || id_stall !== 1'b0) begin errors++; $display("[TB] FAIL load_use_bubble got v=%0b op=%0h Ain=%0h stall=%0b expected 0", idex_valid, IDEXop, Ain, id_stall); end
    setForward(1'b1, 1'b1, 5'd3, 32'h104, 1'b0, 5'd0, 32'h0);
    tick();
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hCAFE);
    #1;
    checks++; if (Ain !== 32'hCAFE || Bin !== 32'h7 || idex_valid !== 1'b1 || IDEXop !== ALUopR) begin errors++; $display("[TB] FAIL load_use_fwd got Ain=%0h Bin=%0h v=%0b expected CAFE/7/1", Ain, Bin, idex_valid); end
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_flush_stall();
    applyStimulus(1'b1, ALUopI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd8, 32'h11, 32'h0, 32'h5);
    flush = 1'b1; stall_in = 1'b1;
    tick();
    checks++; if (idex_valid !== 1'b0 || IDEXop !== 7'd0) begin errors++; $display("[TB] FAIL flush_over_stall got v=%0b op=%0h expected 0/0", idex_valid, IDEXop); end
    flush = 1'b0; stall_in = 1'b0;
    tick();
    checks++; if (Ain !== 32'h11 || Bin !== 32'h5 || idex_rd !== 5'd8 || IDEXop !== ALUopI) begin errors++; $display("[TB] FAIL addi_capture got Ain=%0h Bin=%0h rd=%0d expected 11/5/8", Ain, Bin, idex_rd); end
    stall_in = 1'b1;
    applyStimulus(1'b1, SW, 3'd2, 7'd0, 5'd4, 5'd5, 5'd0, 32'h99, 32'h88, 32'h40);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (idex_valid !== 1'b1 || IDEXop !== ALUopI || Ain !== 32'h11 || Bin !== 32'h5 || idex_rd !== 5'd8) begin
        errors++; $display("[TB] FAIL stall_hold_%0d got v=%0b op=%0h Ain=%0h Bin=%0h rd=%0d expected 1/13/11/5/8", i, idex_valid, IDEXop, Ain, Bin, idex_rd);
      end
    end
    stall_in = 1'b0;
  endtask

  task automatic test_x0();
    applyStimulus(1'b1, ALUopR, 3'd0, 7'd0, 5'd0, 5'd1, 5'd9, 32'h0, 32'h3, 32'h0);
    tick();
    setForward(1'b1, 1'b0, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hEEEE);
    #1;
    checks++; if (Ain !== 32'h0 || Bin !== 32'h3) begin errors++; $display("[TB] FAIL x0_no_fwd got Ain=%0h Bin=%0h expected 0/3", Ain, Bin); end
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    applyStimulus(1'b1, SW, 3'd2, 7'd0, 5'd2, 5'd6, 5'd0, 32'h200, 32'h66, 32'h8);
    tick();
    checks++; if (Bin !== 32'h8 || Ain !== 32'h200 || idex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL sw_imm got Bin=%0h Ain=%0h rw=%0b expected 8/200/0", Bin, Ain, idex_regwrite); end
    applyStimulus(1'b1, OPSYS, 3'd0, 7'd0, 5'd2, 5'd6, 5'd5, 32'h200, 32'h66, 32'h8);
    tick();
    checks++; if (Bin !== 32'h0 || idex_regwrite !== 1'b0) begin errors++; $display("[TB] FAIL nop_op got Bin=%0h rw=%0b expected 0/0", Bin, idex_regwrite); end
  endtask

  task automatic test_store_forward();
    applyStimulus(1'b1, SW, 3'd2, 7'd0, 5'd2, 5'd9, 5'd0, 32'h300, 32'h0, 32'hC);
    tick();
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234);
    #1;
    checks++; if (idex_store_data !== 32'h1234 || Bin !== 32'hC) begin errors++; $display("[TB] FAIL store_fwd got sd=%0h Bin=%0h expected 1234/C", idex_store_data, Bin); end
    memwb_result = 32'h5678;
    tick();
    setForward(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (idex_store_data !== 32'h5678) begin errors++; $display("[TB] FAIL write_through got %0h expected 5678", idex_store_data); end
  endtask

  initial begin
    test_reset();
    test_double_forward();
    test_load_use();
    test_flush_stall();
    test_x0();
    test_store_forward();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
